// File: rtl/change_dispense_ctrl_if.sv
// Bundle of request, coin-breakdown, hopper and status signals for the change dispenser.
interface change_dispense_ctrl_if;
    logic       req_valid;
    logic [8:0] req_amount;
    logic       req_ready;
    logic [8:0] calc_amount;
    logic [3:0] q_cnt;
    logic [2:0] d_cnt;
    logic [2:0] n_cnt;
    logic [2:0] p_cnt;
    logic [3:0] eject;
    logic       coin_sensed;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] dispensed_total;

    modport slave (
        input  req_valid, req_amount, q_cnt, d_cnt, n_cnt, p_cnt, coin_sensed,
        output req_ready, calc_amount, eject, busy, done, error, dispensed_total
    );

    modport master (
        output req_valid, req_amount, q_cnt, d_cnt, n_cnt, p_cnt, coin_sensed,
        input  req_ready, calc_amount, eject, busy, done, error, dispensed_total
    );
endinterface

// File: rtl/change_dispense_ctrl.sv
// Change dispenser sequencer: accepts an amount, loads the coin breakdown,
// then ejects coins largest-first, waiting for a hopper sense after each pulse.
module change_dispense_ctrl #(
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    change_dispense_ctrl_if.slave   bus
);

    localparam int unsigned CMAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, EJECT, WAIT, DONE, ERR} state_t;

    state_t        state, state_nxt;
    logic [3:0]    q_rem;
    logic [2:0]    d_rem, n_rem, p_rem;
    logic [CW-1:0] tcnt;
    logic [3:0]    sel;
    logic [4:0]    sel_val;
    logic [5:0]    coins_left;
    logic          range_err, load_zero, pulse_last, wait_last;

    assign range_err  = bus.calc_amount > 9'd399;
    assign load_zero  = (bus.q_cnt == '0) && (bus.d_cnt == '0) && (bus.n_cnt == '0) && (bus.p_cnt == '0);
    assign pulse_last = tcnt == PULSE_LAST;
    assign wait_last  = tcnt == WAIT_LAST;
    assign coins_left = 6'(q_rem) + 6'(d_rem) + 6'(n_rem) + 6'(p_rem);

    // Pick the highest denomination still owed and its value in cents.
    always_comb begin
        sel     = '0;
        sel_val = '0;
        if (q_rem != '0) begin
            sel     = 4'b1000;
            sel_val = 5'd25;
        end else if (d_rem != '0) begin
            sel     = 4'b0100;
            sel_val = 5'd10;
        end else if (n_rem != '0) begin
            sel     = 4'b0010;
            sel_val = 5'd5;
        end else if (p_rem != '0) begin
            sel     = 4'b0001;
            sel_val = 5'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        bus.error     = 1'b0;
        bus.eject     = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid) state_nxt = LOAD;
            end
            LOAD: begin
                if (range_err)      state_nxt = ERR;
                else if (load_zero) state_nxt = DONE;
                else                state_nxt = EJECT;
            end
            EJECT: begin
                bus.eject = sel;
                if (pulse_last) state_nxt = WAIT;
            end
            WAIT: begin
                // coins_left still includes the coin being confirmed this cycle.
                if (bus.coin_sensed) state_nxt = (coins_left > 6'd1) ? EJECT : DONE;
                else if (wait_last)  state_nxt = ERR;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                bus.error = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, remaining-coin counters, pulse/timeout counter and running total.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.calc_amount     <= '0;
            bus.dispensed_total <= '0;
            q_rem               <= '0;
            d_rem               <= '0;
            n_rem               <= '0;
            p_rem               <= '0;
            tcnt                <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.calc_amount     <= bus.req_amount;
                        bus.dispensed_total <= '0;
                    end
                end
                LOAD: begin
                    tcnt <= '0;
                    if (!range_err) begin
                        q_rem <= bus.q_cnt;
                        d_rem <= bus.d_cnt;
                        n_rem <= bus.n_cnt;
                        p_rem <= bus.p_cnt;
                    end
                end
                EJECT: begin
                    tcnt <= pulse_last ? '0 : tcnt + CW'(1);
                end
                WAIT: begin
                    if (bus.coin_sensed) begin
                        tcnt                <= '0;
                        bus.dispensed_total <= bus.dispensed_total + 9'(sel_val);
                        if (sel[3])      q_rem <= q_rem - 4'd1;
                        else if (sel[2]) d_rem <= d_rem - 3'd1;
                        else if (sel[1]) n_rem <= n_rem - 3'd1;
                        else if (sel[0]) p_rem <= p_rem - 3'd1;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/change_dispense_ctrl.md
# change_dispense_ctrl

Sequencer that takes a change amount from the vending control path, drives the combinational `dispenseChange` coin breakdown, and ejects the resulting coins one at a time through the coin hoppers. It handles a valid/ready request handshake, timed eject pulses, and per-coin hopper confirmation with timeout. It reports done or error and the running value actually dispensed. It sits between the transaction FSM and the hopper drivers.

## Interface
- `PULSE_CYCLES`, default 4: eject pulse width in clocks, must be ≥1.
- `TIMEOUT_CYCLES`, default 255: WAIT cycles allowed per coin before error, must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: change request valid.
- `req_amount` in 9: change in cents.
- `req_ready` out 1: request can be accepted.
- `calc_amount` out 9: registered amount driven to `dispenseChange.change`.
- `q_cnt` in 4, `d_cnt` in 3, `n_cnt` in 3, `p_cnt` in 3: coin counts returned by `dispenseChange`.
- `eject` out 4: one-hot hopper pulse. Bit3 = quarter, bit2 = dime, bit1 = nickel, bit0 = penny.
- `coin_sensed` in 1: hopper reports one coin dropped (single-cycle pulse).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: one-cycle pulse on range error or timeout.
- `dispensed_total` out 9: cents confirmed dispensed for the current or last request.

## Operation
- States: IDLE, LOAD, EJECT, WAIT, DONE, ERR.
- **Reset values** (reset takes effect on the next edge, including mid-dispense):
  - state IDLE, `req_ready`=1.
  - `calc_amount`, `eject`, `busy`, `done`, `error`, `dispensed_total` all 0.
  - Internal counters all 0.
- **IDLE**:
  - `req_ready`=1.
  - On `req_valid & req_ready`: register `calc_amount <= req_amount`, clear `dispensed_total`, go to LOAD.
- **LOAD** (one cycle):
  - If `calc_amount > 399`: go to ERR, with no eject.
  - Otherwise latch the four counts into internal remaining-coin counters.
  - If all counts are zero, go to DONE; else go to EJECT.
- **Coin selection**: highest denomination with a nonzero remaining count, ordered quarter > dime > nickel > penny.
- **EJECT**:
  - The selected `eject` bit is high for exactly `PULSE_CYCLES` cycles; all other bits stay 0.
  - `coin_sensed` is ignored in EJECT.
  - Then go to WAIT.
- **WAIT**:
  - `eject`=0. `coin_sensed` is sampled every cycle.
  - On a sense: decrement the selected counter and add its value (25/10/5/1) to `dispensed_total`.
  - After a sense, go to EJECT if any count remains; otherwise go to DONE.
  - If `TIMEOUT_CYCLES` consecutive WAIT cycles pass without a sense: go to ERR.
- **DONE**: `done`=1 for one cycle, then IDLE.
- **ERR**: `error`=1 for one cycle, `eject`=0, then IDLE.
- `dispensed_total` holds its value after DONE/ERR until the next acceptance. After a timeout it therefore holds the partial value.
- `coin_sensed` in IDLE, LOAD, DONE or ERR is ignored.
- `req_valid` while busy is ignored; the requester holds it until `req_ready`.
- Arithmetic: `dispensed_total` is 9-bit and cannot overflow for amounts ≤399. Counters never decrement below zero.

## Timing
- Acceptance edge = cycle 0. LOAD = cycle 1. First EJECT = cycle 2.
- Per coin: `PULSE_CYCLES` cycles of EJECT plus k cycles of WAIT, where a sense in the first WAIT cycle gives k=1.
- The next EJECT starts the cycle after the sense.
- `done` is asserted the cycle after the final sense. `req_ready` returns the following cycle.
- Amount 0: `done` at cycle 2, `req_ready` at cycle 3.
- Amount >399: `error` at cycle 2, `req_ready` at cycle 3.
- Timeout: `error` at WAIT entry + `TIMEOUT_CYCLES`.

## Test plan
- **Reset**:
  - Assert `rst` 2 cycles.
  - Expect `req_ready`=1 and all other outputs 0.
- **37 cents, immediate senses, PULSE_CYCLES=4**:
  - Expect 4 eject pulses, each 4 cycles wide: quarter, dime, penny, penny.
  - `dispensed_total` steps 25, 35, 36, 37.
  - `done` at cycle 22.
- **Amount 0**:
  - No eject.
  - `done` at cycle 2, `dispensed_total`=0.
- **Amount 399 and 400**:
  - 399: 15 quarters, 2 dimes, 0 nickels, 4 pennies (21 pulses), total 399, `done`.
  - 400: `error` at cycle 2, no eject.
- **Timeout, TIMEOUT_CYCLES=8, amount 30**:
  - Sense the quarter, withhold the nickel sense.
  - Expect `error` 8 cycles after the nickel WAIT entry, `dispensed_total`=25, `eject`=0.
- **Reset mid-EJECT, and request while busy**:
  - `rst` during a quarter pulse: `eject`=0 on the next edge, state IDLE.
  - A request asserted while busy is not accepted until `req_ready`=1.
